// File: rtl/trim_burst_gen.sv
// trim_burst_gen -- trim burst sequencer feeding a BMC encoder.
//
// A START latches PATTERN and sends NUM_BURSTS bursts. Each burst is the
// latched byte repeated BYTES_PER_BURST times, LSB first. Bit timing comes
// from a phase accumulator, and bursts are separated by GAP_CYCLES idle
// cycles. After the last burst the block passes through VCONN and then
// SETTLE, which lasts FIN_CYCLES cycles. FIN pulses on the final SETTLE
// cycle.
//
// Optional feature, macro TRIM_VCONN_HS_EN:
//   defined   - VCONN waits for two consecutive low samples of VCONN_AND.
//   undefined - VCONN lasts one cycle and VCONN_AND is ignored.
//
// Ports:
//   CLK        in   clock (10 MHz nominal)
//   RSTB       in   asynchronous active-low reset
//   START      in   starts/restarts a sequence (level or pulse)
//   ABORT      in   synchronous abort to IDLE, wins over START
//   PATTERN    in   [7:0] byte pattern, latched when START is seen
//   VCONN_AND  in   VCONN status from analog
//   VCONN_OUT  out  combinational copy of START
//   BIT_OUT    out  registered serial bit, 0 outside SEND
//   BVLD       out  one-cycle strobe on the first cycle of every bit
//   BEN        out  high while a burst is being sent
//   BURST_IDX  out  [3:0] current burst, 1-based, 0 in IDLE
//   BUSY       out  high in every state except IDLE
//   FIN        out  one-cycle pulse at the end of a sequence
//   DBG_STATE  out  [2:0] current FSM state, for observation
//
// BVLD/BIT_OUT form a strobe interface with no back-pressure. The consumer
// must take the bit on the BVLD cycle, and BIT_OUT holds until the next
// BVLD.
module trim_burst_gen #(
   parameter int BYTES_PER_BURST = 8,
   parameter int NUM_BURSTS      = 5,
   parameter int RATE_INC        = 3,
   parameter int RATE_MOD        = 100,
   parameter int GAP_CYCLES      = 300,
   parameter int FIN_CYCLES      = 20000
) (
   input  logic       CLK,
   input  logic       RSTB,
   input  logic       START,
   input  logic       ABORT,
   input  logic [7:0] PATTERN,
   input  logic       VCONN_AND,
   output logic       VCONN_OUT,
   output logic       BIT_OUT,
   output logic       BVLD,
   output logic       BEN,
   output logic [3:0] BURST_IDX,
   output logic       BUSY,
   output logic       FIN,
   output logic [2:0] DBG_STATE
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SEND   = 3'd2,
      GAP    = 3'd3,
      VCONN  = 3'd4,
      SETTLE = 3'd5
   } state_t;

   localparam int BITS  = 8 * BYTES_PER_BURST;
   localparam int BIT_W = $clog2(BITS);
   // Holds acc + RATE_INC, which peaks at RATE_MOD + RATE_INC - 1.
   localparam int ACC_W = $clog2(RATE_MOD + RATE_INC);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int FIN_W = $clog2(FIN_CYCLES + 1);

   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);
   localparam logic [ACC_W-1:0] ACC_INC  = ACC_W'(RATE_INC);
   localparam logic [ACC_W-1:0] ACC_MOD  = ACC_W'(RATE_MOD);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [FIN_W-1:0] FIN_LAST = FIN_W'(FIN_CYCLES - 1);
   localparam logic [3:0]       IDX_LAST = 4'(NUM_BURSTS);

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [FIN_W-1:0]  fin_cnt_q, fin_cnt_d;
   logic [7:0]        pat_q, pat_d;
   logic [3:0]        idx_q, idx_d;
   logic              bit_out_q, bit_out_d;
   logic              bvld_q, bvld_d;
   logic              ben_q, ben_d;
   logic              busy_q, busy_d;
   logic              fin_q, fin_d;
   logic [ACC_W-1:0]  acc_sum;
   logic [BIT_W-1:0]  bit_nxt;
`ifdef TRIM_VCONN_HS_EN
   logic              vlow_q, vlow_d;   // previous VCONN_AND sample was low
`else
   logic              unused_vconn_and;
   assign unused_vconn_and = VCONN_AND;
`endif

   assign acc_sum = acc_q + ACC_INC;
   assign bit_nxt = bit_cnt_q + BIT_W'(1);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      fin_cnt_d = fin_cnt_q;
      pat_d     = pat_q;
      idx_d     = idx_q;
      bit_out_d = 1'b0;
      bvld_d    = 1'b0;
`ifdef TRIM_VCONN_HS_EN
      vlow_d    = vlow_q;
`endif
      if (ABORT) begin
         state_d   = IDLE;
         acc_d     = '0;
         bit_cnt_d = '0;
         gap_cnt_d = '0;
         fin_cnt_d = '0;
         idx_d     = 4'd0;
      end else if (START) begin
         state_d   = LOAD;
         pat_d     = PATTERN;
         acc_d     = '0;
         bit_cnt_d = '0;
         gap_cnt_d = '0;
         fin_cnt_d = '0;
         idx_d     = 4'd1;
      end else begin
         case (state_q)
            LOAD: begin
               state_d   = SEND;
               acc_d     = '0;
               bit_cnt_d = '0;
               bvld_d    = 1'b1;
               bit_out_d = pat_q[0];
            end
            SEND: begin
               bit_out_d = bit_out_q;
               if (acc_sum >= ACC_MOD) begin
                  // Carry the remainder forward so the bit edges do not
                  // drift across the burst.
                  acc_d = acc_sum - ACC_MOD;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_out_d = 1'b0;
                     acc_d     = '0;
                     bit_cnt_d = '0;
                     if (idx_q < IDX_LAST) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                     end else begin
                        state_d = VCONN;
`ifdef TRIM_VCONN_HS_EN
                        vlow_d  = 1'b0;
`endif
                     end
                  end else begin
                     bit_cnt_d = bit_nxt;
                     bvld_d    = 1'b1;
                     bit_out_d = pat_q[bit_nxt[2:0]];
                  end
               end else begin
                  acc_d = acc_sum;
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_d   = SEND;
                  gap_cnt_d = '0;
                  idx_d     = idx_q + 4'd1;
                  acc_d     = '0;
                  bit_cnt_d = '0;
                  bvld_d    = 1'b1;
                  bit_out_d = pat_q[0];
               end else begin
                  gap_cnt_d = gap_cnt_q + GAP_W'(1);
               end
            end
            VCONN: begin
`ifdef TRIM_VCONN_HS_EN
               if (!VCONN_AND && vlow_q) begin
                  state_d   = SETTLE;
                  fin_cnt_d = '0;
                  vlow_d    = 1'b0;
               end else begin
                  vlow_d = !VCONN_AND;
               end
`else
               state_d   = SETTLE;
               fin_cnt_d = '0;
`endif
            end
            SETTLE: begin
               if (fin_cnt_q == FIN_LAST) begin
                  state_d   = IDLE;
                  fin_cnt_d = '0;
                  idx_d     = 4'd0;
               end else begin
                  fin_cnt_d = fin_cnt_q + FIN_W'(1);
               end
            end
            default: ;
         endcase
      end
      // Outputs are registered, so they are derived from the next state.
      ben_d  = (state_d == SEND);
      busy_d = (state_d != IDLE);
      fin_d  = (state_d == SETTLE) && (fin_cnt_d == FIN_LAST);
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         fin_cnt_q <= '0;
         pat_q     <= 8'd0;
         idx_q     <= 4'd0;
         bit_out_q <= 1'b0;
         bvld_q    <= 1'b0;
         ben_q     <= 1'b0;
         busy_q    <= 1'b0;
         fin_q     <= 1'b0;
`ifdef TRIM_VCONN_HS_EN
         vlow_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         fin_cnt_q <= fin_cnt_d;
         pat_q     <= pat_d;
         idx_q     <= idx_d;
         bit_out_q <= bit_out_d;
         bvld_q    <= bvld_d;
         ben_q     <= ben_d;
         busy_q    <= busy_d;
         fin_q     <= fin_d;
`ifdef TRIM_VCONN_HS_EN
         vlow_q    <= vlow_d;
`endif
      end
   end

   assign VCONN_OUT = START;
   assign BIT_OUT   = bit_out_q;
   assign BVLD      = bvld_q;
   assign BEN       = ben_q;
   assign BURST_IDX = idx_q;
   assign BUSY      = busy_q;
   assign FIN       = fin_q;
   assign DBG_STATE = state_q;

endmodule
